mux_nx1_rr: RTL and testbench

- Parametrised N-channel, W-bit multiplexer with a registered output and valid/ready handshakes on every input and on the output.
- Supports two selection modes: fixed select (a direct generalisation of the 2:1 mux) and round-robin arbitration across valid channels.
- Sits between multiple producer streams and a single consumer in lab datapaths.
- Output latency is one clock.

---
 rtl/mux_nx1_rr_pkg.sv | 12 +
 rtl/mux_nx1_rr_if.sv | 29 ++
 rtl/mux_nx1_rr_arbiter.sv | 30 +++
 rtl/mux_nx1_rr.sv | 67 ++++++
 tb/tb_mux_nx1_rr.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/mux_nx1_rr_pkg.sv
// Shared constants and helpers for the N:1 multiplexer with round-robin arbitration.
package mux_nx1_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Increment modulo n; correct for any n, not just powers of two.
  function automatic int unsigned inc_mod(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/mux_nx1_rr_if.sv
// Bundle of producer-side and consumer-side handshake signals for mux_nx1_rr.
// Valid/ready: a word moves on a rising edge where valid && ready; valid never waits on ready.
interface mux_nx1_rr_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int SEL_W = $clog2(N_CH);

  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [N_CH*WIDTH-1:0]   in_data;
  logic [N_CH-1:0]         in_valid;
  logic [N_CH-1:0]         in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_ready;
  logic [SEL_W-1:0]        dbg_ptr;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch, dbg_ptr
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch, dbg_ptr
  );
endinterface

// File: rtl/mux_nx1_rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or above ptr wins, with wrap.
module rr_arbiter #(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(ptr) + k) % N_CH;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-channel W-bit multiplexer with registered output, fixed-select or round-robin grant.
module mux_nx1_rr
  import mux_nx1_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  mux_nx1_rr_if.slave     bus
);

  logic [SEL_W-1:0] ptr;
  logic [N_CH-1:0]  rr_grant, fixed_grant, grant;
  logic [SEL_W-1:0] rr_idx, grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             load_en, xfer;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // Out-of-range sel matches no channel, so it can never grant.
  always_comb begin
    fixed_grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.sel == SEL_W'(i) && bus.in_valid[i]) fixed_grant[i] = 1'b1;
    end
  end

  assign grant     = (bus.mode == MODE_RR) ? rr_grant : fixed_grant;
  assign grant_idx = (bus.mode == MODE_RR) ? rr_idx : bus.sel;
  assign load_en   = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = grant & {N_CH{load_en}};
  assign xfer      = |(bus.in_ready & bus.in_valid);
  assign bus.dbg_ptr = ptr;

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) grant_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      ptr           <= '0;
    end else begin
      if (load_en) begin
        bus.out_valid <= xfer;
        if (xfer) begin
          bus.out_data <= grant_data;
          bus.out_ch   <= grant_idx;
        end
      end
      if (xfer && bus.mode == MODE_RR) ptr <= SEL_W'(inc_mod(int'(grant_idx), N_CH));
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr: a 4x8 instance and a 3x16 instance.
module tb_mux_nx1_rr;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mux_nx1_rr_if #(.N_CH(4), .WIDTH(8))  b4 ();
  mux_nx1_rr_if #(.N_CH(3), .WIDTH(16)) b3 ();

  mux_nx1_rr #(.N_CH(4), .WIDTH(8))  u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  mux_nx1_rr #(.N_CH(3), .WIDTH(16)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  d4 [4];
  logic [15:0] d3 [3];
  int          sp [4];
  int          ch;

  initial begin
    d4 = '{8'h11, 8'h22, 8'h3C, 8'h44};
    d3 = '{16'h1111, 16'h2222, 16'h3333};
    sp = '{3, 1, 3, 1};
    rst = 1'b0;
    b4.mode = 1'b0; b4.sel = '0; b4.in_data = '0; b4.in_valid = '0; b4.out_ready = 1'b0;
    b3.mode = 1'b0; b3.sel = '0; b3.in_data = '0; b3.in_valid = '0; b3.out_ready = 1'b0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 64'(b4.out_valid), 0);
    chk("rst_data",  64'(b4.out_data), 0);
    chk("rst_ch",    64'(b4.out_ch), 0);
    chk("rst_ptr",   64'(b4.dbg_ptr), 0);
    tick();
    rst = 1'b0;

    // Fixed mode, sel=2
    b4.in_data  = {d4[3], d4[2], d4[1], d4[0]};
    b4.mode = 1'b0; b4.sel = 2'd2; b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
    #1 chk("fix_rdy", 64'(b4.in_ready), 64'b0100);
    tick();
    chk("fix_valid", 64'(b4.out_valid), 1);
    chk("fix_data",  64'(b4.out_data), 64'h3C);
    chk("fix_ch",    64'(b4.out_ch), 2);
    chk("fix_ptr",   64'(b4.dbg_ptr), 0);
    b4.sel = 2'd3; b4.in_valid = 4'b0111;
    #1 chk("fix_nogrant", 64'(b4.in_ready), 0);
    tick();
    chk("fix_drain", 64'(b4.out_valid), 0);

    // Round-robin with all channels valid
    b4.mode = 1'b1; b4.in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      ch = k % 4;
      #1 chk("rr_rdy", 64'(b4.in_ready), 64'(1) << ch);
      tick();
      chk("rr_ch",    64'(b4.out_ch), 64'(ch));
      chk("rr_valid", 64'(b4.out_valid), 1);
      chk("rr_data",  64'(b4.out_data), 64'(d4[ch]));
    end
    chk("rr_ptr", 64'(b4.dbg_ptr), 2);

    // Backpressure holds everything, then the sequence continues at ch2
    b4.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_rdy", 64'(b4.in_ready), 0);
      tick();
      chk("bp_valid", 64'(b4.out_valid), 1);
      chk("bp_ch",    64'(b4.out_ch), 1);
      chk("bp_data",  64'(b4.out_data), 64'h22);
      chk("bp_ptr",   64'(b4.dbg_ptr), 2);
    end
    b4.out_ready = 1'b1;
    #1 chk("bp_rel_rdy", 64'(b4.in_ready), 64'b0100);
    tick();
    chk("bp_rel_ch",   64'(b4.out_ch), 2);
    chk("bp_rel_data", 64'(b4.out_data), 64'h3C);
    chk("bp_rel_ptr",  64'(b4.dbg_ptr), 3);

    // Sparse round-robin: channels 1 and 3 alternate
    b4.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1 chk("sp_rdy", 64'(b4.in_ready), 64'(1) << sp[k]);
      tick();
      chk("sp_ch", 64'(b4.out_ch), 64'(sp[k]));
    end
    b4.in_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sp1_ch",    64'(b4.out_ch), 1);
      chk("sp1_valid", 64'(b4.out_valid), 1);
      chk("sp1_ptr",   64'(b4.dbg_ptr), 2);
    end

    // Asynchronous reset while holding A5
    b4.mode = 1'b0; b4.sel = 2'd0; b4.in_valid = 4'b0001;
    b4.in_data = {d4[3], d4[2], d4[1], 8'hA5};
    tick();
    chk("hold_data", 64'(b4.out_data), 64'hA5);
    b4.in_valid = '0; b4.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(b4.out_valid), 0);
    chk("arst_data",  64'(b4.out_data), 0);
    chk("arst_ch",    64'(b4.out_ch), 0);
    chk("arst_ptr",   64'(b4.dbg_ptr), 0);
    tick();
    rst = 1'b0;
    b4.mode = 1'b1; b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
    #1 chk("arst_rr_rdy", 64'(b4.in_ready), 64'b0001);
    tick();
    chk("arst_rr_ch", 64'(b4.out_ch), 0);

    // Three channels, 16 bits: wrap at 3
    b3.in_data = {d3[2], d3[1], d3[0]};
    b3.mode = 1'b1; b3.in_valid = 3'b111; b3.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ch = k % 3;
      #1 chk("n3_rdy", 64'(b3.in_ready), 64'(1) << ch);
      tick();
      chk("n3_ch",   64'(b3.out_ch), 64'(ch));
      chk("n3_data", 64'(b3.out_data), 64'(d3[ch]));
    end
    chk("n3_ptr", 64'(b3.dbg_ptr), 1);
    b3.mode = 1'b0; b3.sel = 2'd3;
    for (int k = 0; k < 3; k++) begin
      #1 chk("n3_sel3_rdy", 64'(b3.in_ready), 0);
      tick();
      chk("n3_sel3_valid", 64'(b3.out_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
